life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
Parametrised Conway Game-of-Life engine for the VGA demoscene top level; successor to the fixed 8x8 in-top-level board.
- Holds a 2^COLS_LOG2 x 2^ROWS_LOG2 board in a double buffer.
- Computes each generation sequentially, one cell per clock. Optional toroidal wrap.
- Commits the new generation only on a frame tick (vblank), so the renderer never sees a torn board.
- Adds step, clear and seed-reload controls, plus population and generation counters.

Parameters:
COLS_LOG2, 3, log2 of board width (COLS = 2^COLS_LOG2)
ROWS_LOG2, 3, log2 of board height (ROWS = 2^ROWS_LOG2)
WRAP, 0, 0 = cells outside the board are dead; 1 = toroidal, edges wrap modulo COLS/ROWS
FRAMES_PER_GEN, 60, frame ticks between generations in run mode (>=1)
INIT_PATTERN, 64'h0, SIZE-bit seed (SIZE = COLS*ROWS); bit i = cell i

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  reset, asynchronous, active-high
frame_tick  in  1  one-cycle pulse per frame, at vblank start
run  in  1  level; 1 = auto-advance every FRAMES_PER_GEN ticks
step  in  1  pulse; request a single generation
clear  in  1  pulse; kill all cells
load_seed  in  1  pulse; reload INIT_PATTERN
rd_addr  in  COLS_LOG2+ROWS_LOG2  renderer cell address, row*COLS+col
rd_data  out  1  display-buffer cell at rd_addr, combinational
busy  out  1  1 in COMPUTE or WAIT_VB
gen_done  out  1  one-cycle pulse on the cycle the display buffer updates
gen_count  out  16  generations committed since reset/clear/load, wraps at 65535->0
alive_count  out  clog2(SIZE+1)  live cells in the display buffer

Behaviour:
Reset (rst_n=1), asynchronous:
- display = INIT_PATTERN; next buffer = 0.
- state IDLE; frame counter fc = 0; cell index ci = 0.
- busy=0, gen_done=0, gen_count=0, alive_count=popcount(INIT_PATTERN).

States:
- IDLE
  - run=1: each frame_tick increments fc. A tick arriving with fc==FRAMES_PER_GEN-1 zeroes fc and enters COMPUTE next cycle.
  - run=0: fc holds. step=1 enters COMPUTE next cycle (step is ignored outside IDLE).
  - If step=1 and a qualifying tick occur together, only one generation starts.
- COMPUTE
  - One cell per cycle, ci = 0..SIZE-1. Next cycle after ci==SIZE-1 -> WAIT_VB. Total SIZE cycles.
  - Neighbour count: 4 bits, from the display buffer only, 8 neighbours.
  - WRAP=0: out-of-range neighbours read as 0.
  - WRAP=1: row/col computed modulo ROWS/COLS via natural index-width overflow.
  - Rule: live stays live iff n is 2 or 3; dead becomes live iff n==3. Result written to next[ci].
  - Running population accumulated into a shadow counter.
- WAIT_VB
  - On frame_tick: display <= next, alive_count <= shadow, gen_count += 1, gen_done=1 for that cycle.
  - Next state IDLE.
  - Ticks in COMPUTE/WAIT_VB do not advance fc.
- The display buffer is never modified during COMPUTE. rd_data is stable except at commit/clear/load edges.

Clear and load_seed:
- Accepted in any state. Abort COMPUTE/WAIT_VB and go to IDLE next cycle, with no gen_done.
- clear: display=0, alive_count=0, gen_count=0, fc=0.
- load_seed: display=INIT_PATTERN, alive_count=popcount(INIT_PATTERN), gen_count=0, fc=0.
- If both are asserted together, clear wins.
- A clear/load on the same cycle as a WAIT_VB commit tick wins; the commit is discarded.

Widths: alive_count uses width clog2(SIZE+1) so a full board (SIZE) is representable. gen_count wraps silently.

Test Plan:
- Reset with INIT_PATTERN = blinker at cells 19,27,35, WRAP=0 -> rd_data 1 only at 19/27/35; alive_count=3, gen_count=0, busy=0.
- Blinker, run=0, step pulse, frame_tick 80 cycles later:
  - busy=1 for 64 cycles of COMPUTE, then WAIT_VB.
  - gen_done on the tick cycle; cells 26,27,28 live; alive_count=3, gen_count=1.
  - Second step+tick returns to 19/27/35.
- Block still life 27,28,35,36, run=1, FRAMES_PER_GEN=2 -> gen_done on every 2nd tick after compute completes; board unchanged; gen_count increments each generation.
- Glider at top-left corner, WRAP=1, 32 steps -> glider translated by (+8,+8) mod 8 = original cells; alive_count=5 throughout.
  - Same stimulus with WRAP=0 -> glider collapses to a block (alive_count=4) at the bottom-right corner.
- clear pulse mid-COMPUTE (ci=30):
  - Next cycle IDLE, busy=0, all rd_data=0, alive_count=0, gen_count=0.
  - No gen_done on the following frame_tick.
- load_seed and clear asserted together -> board all 0. load_seed alone on a WAIT_VB tick cycle -> board = INIT_PATTERN, no gen_done, gen_count=0.

Source files
------------

// File: rtl/life_engine.sv
// Game-of-Life engine: double-buffered board that evolves one cell per clock
// and commits each new generation to the display buffer only on a frame tick.
module life_engine #(
  parameter int COLS_LOG2      = 3,
  parameter int ROWS_LOG2      = 3,
  parameter int WRAP           = 0,
  parameter int FRAMES_PER_GEN = 60,
  parameter logic [(2**COLS_LOG2)*(2**ROWS_LOG2)-1:0] INIT_PATTERN = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_tick,
  input  logic                                 run,
  input  logic                                 step,
  input  logic                                 clear,
  input  logic                                 load_seed,
  input  logic [COLS_LOG2+ROWS_LOG2-1:0]       rd_addr,
  output logic                                 rd_data,
  output logic                                 busy,
  output logic                                 gen_done,
  output logic [15:0]                          gen_count,
  output logic [$clog2((2**COLS_LOG2)*(2**ROWS_LOG2)+1)-1:0] alive_count,
  output logic [1:0]                           dbg_state
);

  localparam int AW   = COLS_LOG2 + ROWS_LOG2;
  localparam int SIZE = 2**AW;
  localparam int CW   = $clog2(SIZE + 1);
  localparam int FCW  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [FCW-1:0]       FC_LAST = FCW'(FRAMES_PER_GEN - 1);
  localparam logic [ROWS_LOG2-1:0] ROW_MAX = '1;
  localparam logic [COLS_LOG2-1:0] COL_MAX = '1;
  localparam logic [AW-1:0]        CI_LAST = '1;

  function automatic logic [CW-1:0] f_popcount(input logic [SIZE-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < SIZE; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  localparam logic [CW-1:0] INIT_POP = f_popcount(INIT_PATTERN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COMPUTE = 2'd1, S_WAIT_VB = 2'd2} state_t;

  state_t          r_state, w_next_state;
  logic [SIZE-1:0] r_disp, r_next;
  logic [FCW-1:0]  r_fc;
  logic [AW-1:0]   r_ci;
  logic [CW-1:0]   r_shadow, r_alive;
  logic [15:0]     r_gen;

  logic                 w_gen_tick;
  logic                 w_new_cell;
  logic [3:0]           w_ncount;
  logic [ROWS_LOG2-1:0] w_row;
  logic [COLS_LOG2-1:0] w_col;

  assign w_row      = r_ci[AW-1:COLS_LOG2];
  assign w_col      = r_ci[COLS_LOG2-1:0];
  assign w_gen_tick = run && frame_tick && (r_fc == FC_LAST);

  // Neighbour indices wrap through natural overflow; with WRAP=0 the edge
  // neighbours are masked instead.
  always_comb begin
    logic [ROWS_LOG2-1:0] nr;
    logic [COLS_LOG2-1:0] nc;
    logic                 ok;
    w_ncount = '0;
    nr = '0;
    nc = '0;
    ok = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = w_row + ROWS_LOG2'(dr);
        nc = w_col + COLS_LOG2'(dc);
        ok = (WRAP != 0) ||
             (!(dr == -1 && w_row == '0) && !(dr == 1 && w_row == ROW_MAX) &&
              !(dc == -1 && w_col == '0) && !(dc == 1 && w_col == COL_MAX));
        if (!(dr == 0 && dc == 0) && ok) w_ncount = w_ncount + 4'(r_disp[{nr, nc}]);
      end
    end
  end

  assign w_new_cell = (w_ncount == 4'd3) || (r_disp[r_ci] && w_ncount == 4'd2);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear || load_seed) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (step || w_gen_tick) w_next_state = S_COMPUTE;
        S_COMPUTE: if (r_ci == CI_LAST)    w_next_state = S_WAIT_VB;
        S_WAIT_VB: if (frame_tick)         w_next_state = S_IDLE;
        default:                           w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    gen_done = (r_state == S_WAIT_VB) && frame_tick && !clear && !load_seed;
  end

  // Clear and seed reload override every state, so a commit tick on the
  // same cycle is dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_disp   <= INIT_PATTERN;
      r_next   <= '0;
      r_fc     <= '0;
      r_ci     <= '0;
      r_shadow <= '0;
      r_alive  <= INIT_POP;
      r_gen    <= '0;
    end else if (clear) begin
      r_disp  <= '0;
      r_alive <= '0;
      r_gen   <= '0;
      r_fc    <= '0;
      r_ci    <= '0;
    end else if (load_seed) begin
      r_disp  <= INIT_PATTERN;
      r_alive <= INIT_POP;
      r_gen   <= '0;
      r_fc    <= '0;
      r_ci    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ci     <= '0;
          r_shadow <= '0;
          if (run && frame_tick) r_fc <= (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
        end
        S_COMPUTE: begin
          r_next[r_ci] <= w_new_cell;
          r_shadow     <= r_shadow + CW'(w_new_cell);
          r_ci         <= r_ci + 1'b1;
        end
        S_WAIT_VB: begin
          if (frame_tick) begin
            r_disp  <= r_next;
            r_alive <= r_shadow;
            r_gen   <= r_gen + 16'd1;
          end
        end
        default: r_ci <= '0;
      endcase
    end
  end

  assign rd_data     = r_disp[rd_addr];
  assign gen_count   = r_gen;
  assign alive_count = r_alive;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: four instances (blinker, wrapped glider, bounded
// glider, dense random seed) driven in lockstep and compared to a rule model.
module tb_life_engine;

  localparam logic [63:0] BLINKER = 64'h0000_0008_0808_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] BLOCK   = 64'hC0C0_0000_0000_0000;
  localparam logic [63:0] RANDSD  = 64'h3C5A_96E1_0F72_B4D8;

  logic       clk, rst_n, frame_tick, run, step, clear, load_seed;
  logic [5:0] rd_addr;
  logic       rd [4];
  logic       bz [4];
  logic       gd [4];
  logic [15:0] gc [4];
  logic [6:0]  ac [4];
  logic [1:0]  st [4];

  logic [63:0] init_b [4];
  logic [63:0] mb [4];
  logic [63:0] rb [4];
  bit          wrap_m [4];
  int          mgen;
  int          checks, errors;

  life_engine #(.WRAP(0), .FRAMES_PER_GEN(2), .INIT_PATTERN(BLINKER)) u_d0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_seed(load_seed), .rd_addr(rd_addr), .rd_data(rd[0]),
    .busy(bz[0]), .gen_done(gd[0]), .gen_count(gc[0]), .alive_count(ac[0]), .dbg_state(st[0]));
  life_engine #(.WRAP(1), .FRAMES_PER_GEN(2), .INIT_PATTERN(GLIDER)) u_d1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_seed(load_seed), .rd_addr(rd_addr), .rd_data(rd[1]),
    .busy(bz[1]), .gen_done(gd[1]), .gen_count(gc[1]), .alive_count(ac[1]), .dbg_state(st[1]));
  life_engine #(.WRAP(0), .FRAMES_PER_GEN(2), .INIT_PATTERN(GLIDER)) u_d2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_seed(load_seed), .rd_addr(rd_addr), .rd_data(rd[2]),
    .busy(bz[2]), .gen_done(gd[2]), .gen_count(gc[2]), .alive_count(ac[2]), .dbg_state(st[2]));
  life_engine #(.WRAP(1), .FRAMES_PER_GEN(2), .INIT_PATTERN(RANDSD)) u_d3 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .clear(clear), .load_seed(load_seed), .rd_addr(rd_addr), .rd_data(rd[3]),
    .busy(bz[3]), .gen_done(gd[3]), .gen_count(gc[3]), .alive_count(ac[3]), .dbg_state(st[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rule on an 8x8 grid, straight from the birth/survival rules.
  function automatic logic [63:0] life_next(input logic [63:0] b, input bit wrap);
    logic [63:0] nb;
    int n, rr, cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
                n += int'(b[rr*8+cc]);
              end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                n += int'(b[rr*8+cc]);
              end
            end
          end
        end
        nb[r*8+c] = b[r*8+c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_models();
    for (int k = 0; k < 4; k++) mb[k] = life_next(mb[k], wrap_m[k]);
    mgen++;
  endtask

  task automatic check_all(input string tag, input bit exp_busy);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1;
      for (int k = 0; k < 4; k++) rb[k][a] = rd[k];
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_board%0d", tag, k), rb[k], mb[k]);
      chk($sformatf("%s_alive%0d", tag, k), 64'(ac[k]), 64'($countones(mb[k])));
      chk($sformatf("%s_gen%0d", tag, k), 64'(gc[k]), 64'(mgen[15:0]));
      chk($sformatf("%s_busy%0d", tag, k), 64'(bz[k]), 64'(exp_busy));
    end
    cyc();
  endtask

  task automatic do_tick(input string tag, input bit exp_gd);
    frame_tick = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_gd%0d", tag, k), 64'(gd[k]), 64'(exp_gd));
    cyc();
    frame_tick = 1'b0;
  endtask

  // One stepped generation; the display must hold the old board until the tick.
  task automatic gen_step(input string tag);
    int gap, a;
    gap = $urandom_range(70, 110);
    step = 1'b1;
    cyc();
    step = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      a = $urandom_range(0, 63);
      rd_addr = 6'(a);
      #1;
      chk($sformatf("%s_busy_c%0d", tag, i), 64'(bz[0]), 64'd1);
      chk($sformatf("%s_hold_c%0d", tag, i), 64'(rd[3]), 64'(mb[3][a]));
      chk($sformatf("%s_nogd_c%0d", tag, i), 64'(gd[3]), 64'd0);
    end
    cyc();
    do_tick(tag, 1'b1);
    advance_models();
    check_all(tag, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mgen = 0;
    init_b[0] = BLINKER; init_b[1] = GLIDER; init_b[2] = GLIDER; init_b[3] = RANDSD;
    wrap_m[0] = 1'b0; wrap_m[1] = 1'b1; wrap_m[2] = 1'b0; wrap_m[3] = 1'b1;
    for (int k = 0; k < 4; k++) mb[k] = init_b[k];
    rst_n = 1'b1;
    frame_tick = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0; load_seed = 1'b0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_gd%0d", k), 64'(gd[k]), 64'd0);
    cyc();
    check_all("reset", 1'b0);

    // First generation: blinker flips to the horizontal phase.
    gen_step("gen1");
    chk("blinker_horiz", rb[0], 64'h0000_0000_1C00_0000);
    gen_step("gen2");
    chk("blinker_back", rb[0], BLINKER);
    for (int g = 3; g <= 32; g++) gen_step($sformatf("gen%0d", g));
    chk("glider_wrap_home", rb[1], GLIDER);
    chk("glider_wrap_pop", 64'(ac[1]), 64'd5);
    chk("glider_block", rb[2], BLOCK);
    chk("glider_block_pop", 64'(ac[2]), 64'd4);

    // Run mode, FRAMES_PER_GEN=2: two idle ticks start a compute, the next tick commits.
    run = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      repeat ($urandom_range(70, 110)) cyc();
      do_tick($sformatf("run_t%0d", t), (t % 3) == 0);
      if ((t % 3) == 0) begin
        advance_models();
        check_all($sformatf("run_c%0d", t), 1'b0);
      end else if ((t % 3) == 1) begin
        check_all($sformatf("run_i%0d", t), 1'b0);
      end
    end
    chk("block_still", rb[2], BLOCK);
    run = 1'b0;

    // Clear while ci==30.
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (30) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("clr_busy%0d", k), 64'(bz[k]), 64'd0);
    cyc();
    for (int k = 0; k < 4; k++) mb[k] = '0;
    mgen = 0;
    check_all("clear", 1'b0);
    do_tick("clr_tick", 1'b0);
    check_all("clear_after", 1'b0);

    // Seed reload, then clear beating reload.
    load_seed = 1'b1;
    cyc();
    load_seed = 1'b0;
    for (int k = 0; k < 4; k++) mb[k] = init_b[k];
    check_all("load", 1'b0);
    load_seed = 1'b1;
    clear = 1'b1;
    cyc();
    load_seed = 1'b0;
    clear = 1'b0;
    for (int k = 0; k < 4; k++) mb[k] = '0;
    check_all("load_clr", 1'b0);

    // Reload on the commit tick discards the commit.
    load_seed = 1'b1;
    cyc();
    load_seed = 1'b0;
    for (int k = 0; k < 4; k++) mb[k] = init_b[k];
    gen_step("lgen1");
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (80) cyc();
    frame_tick = 1'b1;
    load_seed = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("ltick_gd%0d", k), 64'(gd[k]), 64'd0);
    cyc();
    frame_tick = 1'b0;
    load_seed = 1'b0;
    for (int k = 0; k < 4; k++) mb[k] = init_b[k];
    mgen = 0;
    check_all("load_tick", 1'b0);
    do_tick("ltick_after", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
